// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged FIFO family.
//   FIFO_STD / FIFO_FWFT : read-mode selectors for the FWFT parameter.
//   clog2()              : constant-function ceiling log2, used to size the
//                          occupancy counter and threshold constants.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_flagged_ram.sv
// Simple dual-port RAM backing the flagged FIFO.
//   clk    : rising-edge clock
//   reset  : synchronous active-high, clears only the registered read data
//   we     : write enable, wdata written to mem[waddr]
//   re     : read enable for the registered read port (ignored when ASYNC_RD)
//   raddr  : read address
//   rdata  : read data; registered (1-cycle latency) or combinational
// On an address collision the read returns the word held before the write.
module fifo_flagged_ram #(
  parameter int SIZE     = 3,
  parameter int WIDTH    = 8,
  parameter bit ASYNC_RD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [SIZE-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [SIZE-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** SIZE;

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (ASYNC_RD) begin : g_async_rd
      // Combinational read: the old word stays visible until the write edge.
      assign rdata = mem[raddr];
    end else begin : g_sync_rd
      logic [WIDTH-1:0] rdata_reg;

      // Non-blocking read sees the pre-write contents, giving
      // read-before-write on a collision.
      always_ff @(posedge clk) begin
        if (reset) begin
          rdata_reg <= '0;
        end else if (re) begin
          rdata_reg <= mem[raddr];
        end
      end

      assign rdata = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, programmable almost-full /
// almost-empty thresholds, optional first-word-fall-through reads and
// overflow/underflow error pulses.
//   clk, reset      : clock, synchronous active-high reset
//   push, Din       : write request and data
//   pop, Dout       : read request and data (registered, or FWFT head word)
//   full, empty     : count == 2**SIZE / count == 0
//   almost_full     : count >= AF_LEVEL
//   almost_empty    : count <= AE_LEVEL
//   count           : occupancy 0..2**SIZE
//   overflow        : one-cycle pulse after a rejected push
//   underflow       : one-cycle pulse after a rejected pop
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int SIZE     = 3,
  parameter int WIDTH    = 8,
  parameter int FWFT     = FIFO_STD,
  parameter int AF_LEVEL = 2 ** SIZE - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [SIZE:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 2 ** SIZE;
  // Counter must hold DEPTH itself, hence one bit beyond the address width.
  localparam int CNT_W = clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [SIZE-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             full_reg, empty_reg, almost_full_reg, almost_empty_reg;
  logic             overflow_reg, underflow_reg;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] ram_rdata;

  // A push while full is accepted only when a pop frees a slot that cycle.
  assign pop_ok     = pop && !empty_reg;
  assign push_ok    = push && (!full_reg || pop_ok);
  assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + SIZE'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + SIZE'(1);
      end
      count_reg <= count_next;
      // Flags come from count_next so they line up with count every cycle.
      full_reg         <= (count_next == DEPTH_C);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_C);
      almost_empty_reg <= (count_next <= AE_C);
      overflow_reg     <= push && !push_ok;
      underflow_reg    <= pop && empty_reg;
    end
  end

  fifo_flagged_ram #(
    .SIZE     (SIZE),
    .WIDTH    (WIDTH),
    .ASYNC_RD (FWFT == FIFO_FWFT)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok),
    .waddr (wr_ptr_reg),
    .wdata (Din),
    .re    (pop_ok),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft_out
      // Head word is meaningless while empty; force zero so reset shows 0.
      assign Dout = empty_reg ? '0 : ram_rdata;
    end else begin : g_std_out
      assign Dout = ram_rdata;
    end
  endgenerate

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_flagged.sv
module tb_fifo_flagged;

  logic       clk = 1'b0;
  logic       reset;

  // Standard-mode instance
  logic       push, pop;
  logic [7:0] din, dout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;

  // FWFT-mode instance
  logic       f_push, f_pop;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0] f_count;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  fifo_flagged #(
    .SIZE(3), .WIDTH(8), .FWFT(0), .AF_LEVEL(7), .AE_LEVEL(1)
  ) u_std (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .Din          (din),
    .Dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  fifo_flagged #(
    .SIZE(3), .WIDTH(8), .FWFT(1), .AF_LEVEL(7), .AE_LEVEL(1)
  ) u_fwft (
    .clk          (clk),
    .reset        (reset),
    .push         (f_push),
    .pop          (f_pop),
    .Din          (f_din),
    .Dout         (f_dout),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_almost_full),
    .almost_empty (f_almost_empty),
    .count        (f_count),
    .overflow     (f_overflow),
    .underflow    (f_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_std(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      push = 1'b1;
      din  = first + 8'(i);
      tick();
    end
    push = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] model_q[$];
    logic [7:0] exp_b;

    reset = 1'b1;
    push = 1'b0; pop = 1'b0; din = '0;
    f_push = 1'b0; f_pop = 1'b0; f_din = '0;
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_af", 32'(almost_full), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);

    // 1. Fill, overflow, drain
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1;
      din  = 8'(i);
      tick();
      check($sformatf("t1_cnt%0d", i), 32'(count), 32'(i));
      check($sformatf("t1_af%0d", i), 32'(almost_full), 32'(i >= 7));
      check($sformatf("t1_full%0d", i), 32'(full), 32'(i == 8));
    end
    din = 8'h99;
    tick();
    check("t1_ovf", 32'(overflow), 1);
    check("t1_ovf_cnt", 32'(count), 8);
    push = 1'b0;
    tick();
    check("t1_ovf_pulse_end", 32'(overflow), 0);
    for (int i = 1; i <= 8; i++) begin
      pop = 1'b1;
      tick();
      check($sformatf("t1_dout%0d", i), 32'(dout), 32'(i));
      check($sformatf("t1_dcnt%0d", i), 32'(count), 32'(8 - i));
      check($sformatf("t1_ae%0d", i), 32'(almost_empty), 32'((8 - i) <= 1));
      check($sformatf("t1_empty%0d", i), 32'(empty), 32'(i == 8));
    end
    pop = 1'b0;
    tick();

    // 2. Push + pop while full
    fill_std(8'h01, 8);
    check("t2_full", 32'(full), 1);
    push = 1'b1; pop = 1'b1; din = 8'hAA;
    tick();
    push = 1'b0;
    check("t2_dout", 32'(dout), 32'h01);
    check("t2_cnt", 32'(count), 8);
    check("t2_ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'hAA : 8'(i + 2);
      tick();
      check($sformatf("t2_drain%0d", i), 32'(dout), 32'(exp_b));
    end
    pop = 1'b0;
    tick();
    check("t2_empty", 32'(empty), 1);

    // 3. Push + pop while empty
    push = 1'b1; pop = 1'b1; din = 8'h55;
    tick();
    push = 1'b0;
    check("t3_unf", 32'(underflow), 1);
    check("t3_cnt", 32'(count), 1);
    check("t3_dout_hold", 32'(dout), 32'hAA);
    tick();
    pop = 1'b0;
    check("t3_dout", 32'(dout), 32'h55);
    check("t3_unf_end", 32'(underflow), 0);
    check("t3_empty", 32'(empty), 1);

    // 4. FWFT visibility
    check("t4_pre_empty", 32'(f_empty), 1);
    f_push = 1'b1; f_din = 8'h33;
    tick();
    f_push = 1'b0;
    check("t4_empty", 32'(f_empty), 0);
    check("t4_dout", 32'(f_dout), 32'h33);
    tick();
    check("t4_dout_hold", 32'(f_dout), 32'h33);
    f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    check("t4_pop_empty", 32'(f_empty), 1);
    f_push = 1'b1; f_din = 8'h44;
    tick();
    f_din = 8'h45;
    tick();
    f_push = 1'b0;
    check("t4_head", 32'(f_dout), 32'h44);
    f_pop = 1'b1;
    tick();
    f_pop = 1'b0;
    check("t4_next", 32'(f_dout), 32'h45);
    check("t4_cnt", 32'(f_count), 1);

    // 5. Wrap-around at occupancy 3
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; din = 8'h40 + 8'(i);
      model_q.push_back(din);
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      push = 1'b1; pop = 1'b1; din = 8'h60 + 8'(k);
      model_q.push_back(din);
      exp_b = model_q.pop_front();
      tick();
      check($sformatf("t5_dout%0d", k), 32'(dout), 32'(exp_b));
      check($sformatf("t5_cnt%0d", k), 32'(count), 3);
    end
    push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_b = model_q.pop_front();
      tick();
      check($sformatf("t5_drain%0d", i), 32'(dout), 32'(exp_b));
    end
    pop = 1'b0;
    tick();

    // 6. Reset mid-stream
    fill_std(8'h11, 5);
    check("t6_pre_cnt", 32'(count), 5);
    reset = 1'b1; push = 1'b1; din = 8'h77;
    tick();
    reset = 1'b0; push = 1'b0;
    check("t6_cnt", 32'(count), 0);
    check("t6_empty", 32'(empty), 1);
    check("t6_ae", 32'(almost_empty), 1);
    check("t6_dout", 32'(dout), 0);
    push = 1'b1; din = 8'h5A;
    tick();
    push = 1'b0; pop = 1'b1;
    tick();
    pop = 1'b0;
    check("t6_new_data", 32'(dout), 32'h5A);
    check("t6_end_empty", 32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
- Parametrised successor to the basic single-clock FIFO, for buffering streams between the PCIe/RIFFA channel logic and user datapaths.
- Adds:
  - occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - optional first-word-fall-through (FWFT) read mode;
  - push+pop together while full;
  - overflow/underflow error pulses.
- Single clock domain; the memory is a separate inferred RAM sub-module.

Parameters:
- SIZE, 3: address bits. Depth = 2**SIZE words. Legal range 1..12.
- WIDTH, 8: data width in bits.
- FWFT, 0:
  - 0 = standard mode: Dout is registered and valid the cycle after an accepted pop.
  - 1 = FWFT mode: Dout shows the head word whenever empty=0.
- AF_LEVEL, 2**SIZE-1: almost_full asserts when count >= AF_LEVEL. Legal range 1..2**SIZE.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL. Legal range 0..2**SIZE-1.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- push, input, 1: write request.
- pop, input, 1: read request.
- Din, input, WIDTH: write data.
- Dout, output, WIDTH: read data.
- full, output, 1: count == 2**SIZE.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AF_LEVEL.
- almost_empty, output, 1: count <= AE_LEVEL.
- count, output, SIZE+1: current occupancy, 0..2**SIZE.
- overflow, output, 1: one-cycle pulse when a push is rejected.
- underflow, output, 1: one-cycle pulse when a pop is rejected.

Behaviour:
- Reset (synchronous, active-high; sampled on the clk rising edge; overrides all requests that cycle):
  - Radd=0, Wadd=0, count=0;
  - empty=1, full=0, almost_empty=1, almost_full=0;
  - Dout=0, overflow=0, underflow=0;
  - memory contents are not cleared.
  - Reset mid-stream discards all stored words. The first cycle after reset behaves as an empty FIFO.
- Acceptance rules:
  - pop_ok = pop && !empty.
  - push_ok = push && (!full || pop_ok). A push while full is accepted only if a pop is accepted in the same cycle.
- Rejections:
  - push && !push_ok gives overflow=1 on the next cycle.
  - pop && empty gives underflow=1 on the next cycle, even if push is also asserted.
  - Pointers and count are unchanged by rejected requests.
- Pointers:
  - Wadd advances on push_ok; Radd advances on pop_ok.
  - Both are SIZE bits and wrap modulo 2**SIZE naturally.
- Count update:
  - count_nxt = count + push_ok - pop_ok, registered.
  - All four flags are registered, derived from count_nxt, and therefore coherent with count every cycle.
- Standard mode (FWFT=0):
  - On pop_ok, Dout <= mem[Radd] (1-cycle latency); otherwise Dout holds.
  - Empty with push and pop together: the push is accepted, the pop is rejected (underflow pulse), and Dout holds.
- FWFT mode (FWFT=1):
  - Dout = mem[Radd] via asynchronous read, valid whenever empty=0.
  - A push into an empty FIFO makes the word visible on Dout, with empty=0, on the next cycle.
  - pop_ok presents the next word, or empty=1, on the following cycle.
  - While empty=1, Dout value is don't-care.
- Write:
  - mem[Wadd] <= Din on push_ok.
  - Full with push and pop together: the read takes the old head at Radd while the write goes to Wadd. Since Wadd==Radd when full, read-before-write ordering is required.
- Latency: push to empty deassert is 1 cycle. Push to visible data is 1 cycle in FWFT mode, and 2 cycles in standard mode (push, then pop).

Decomposition:
- Shared package fifo_pkg:
  - mode constants FIFO_STD=0 and FIFO_FWFT=1;
  - a clog2 helper function for count/threshold width checks.
- Sub-module fifo_flagged_ram:
  - simple dual-port RAM, depth 2**SIZE, WIDTH bits;
  - synchronous write;
  - read port registered or asynchronous, selected by an ASYNC_RD parameter (driven from FWFT);
  - read-before-write on an address collision.
- The parent holds pointers, count, flags and error pulses.

Test Plan:
1. SIZE=3, FWFT=0, AF=7, AE=1. Push 0x01..0x08 on consecutive cycles:
   - count reaches 8, full=1;
   - almost_full rises when count=7;
   - a 9th push gives overflow=1 for one cycle and count stays 8;
   - then 8 pops give Dout 0x01..0x08 one cycle after each pop, empty=1 after the last, almost_empty=1 at count<=1.
2. Fill to full, then push 0xAA and pop together:
   - Dout=0x01, count stays 8, no overflow;
   - draining yields 0x02..0x08 then 0xAA.
3. Empty FIFO, push 0x55 and pop together:
   - underflow pulses, count=1, Dout unchanged;
   - the next pop returns 0x55.
4. FWFT=1, push 0x33:
   - the next cycle shows empty=0 and Dout=0x33 with no pop;
   - pop gives empty=1 the following cycle.
5. Wrap-around: perform 20 push/pop pairs at occupancy 3; data order is preserved across the pointer wrap and count stays 3.
6. Fill with 5 words, assert reset for 1 cycle while push=1:
   - count=0, empty=1, almost_empty=1, Dout=0;
   - the next push/pop returns the new data only.
